// File: rtl/lane_move_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : lane_move_scheduler_if
// Brief    : Control/strobe bundle between a game controller and the lane
//            move scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface lane_move_scheduler_if #(
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 4
);
    logic                         frame_tick;
    logic                         start;
    logic                         pause;
    logic                         collision;
    logic [NUM_LANES*CNT_W-1:0]   lane_period;
    logic [NUM_LANES-1:0]         move;
    logic                         follower_reset;
    logic [1:0]                   state;
    logic [15:0]                  frames_run;

    modport master (
        output frame_tick, start, pause, collision, lane_period,
        input  move, follower_reset, state, frames_run
    );

    modport slave (
        input  frame_tick, start, pause, collision, lane_period,
        output move, follower_reset, state, frames_run
    );
endinterface
`default_nettype wire

// File: rtl/lane_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lane_move_scheduler
// Brief    : Per-lane move strobe generator with idle/load/run/halt control.
// Revision : 1.0 - initial release
// ============================================================================
module lane_move_scheduler #(
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    lane_move_scheduler_if.slave bus
);
    localparam logic [1:0]       c_IDLE       = 2'd0;
    localparam logic [1:0]       c_LOAD       = 2'd1;
    localparam logic [1:0]       c_RUN        = 2'd2;
    localparam logic [1:0]       c_HALT       = 2'd3;
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);
    localparam logic [15:0]      c_FRAMES_MAX = 16'hFFFF;

    logic [1:0]           r_state;
    logic [NUM_LANES-1:0] r_move;
    logic                 r_follower_reset;
    logic [15:0]          r_frames_run;
    logic [CNT_W-1:0]     r_cd      [NUM_LANES];
    logic [CNT_W-1:0]     w_period  [NUM_LANES];
    logic [CNT_W-1:0]     w_cd_next [NUM_LANES];
    logic [NUM_LANES-1:0] w_fire;

    // A zero countdown means the lane was stopped; it restarts as if freshly
    // loaded, so this tick already counts toward its first strobe.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [CNT_W-1:0] w_eff;
            assign w_period[gi]  = bus.lane_period[gi*CNT_W +: CNT_W];
            assign w_eff         = (r_cd[gi] == '0) ? w_period[gi] : r_cd[gi];
            assign w_fire[gi]    = (w_period[gi] != '0) && (w_eff <= c_CNT_ONE);
            assign w_cd_next[gi] = (w_period[gi] == '0) ? '0 :
                                   (w_eff <= c_CNT_ONE) ? w_period[gi] :
                                   (w_eff - c_CNT_ONE);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= c_IDLE;
            r_move           <= '0;
            r_follower_reset <= 1'b1;
            r_frames_run     <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_cd[i] <= '0;
            end
        end else begin
            r_move <= '0;
            case (r_state)
                c_IDLE: begin
                    r_follower_reset <= 1'b1;
                    if (bus.start) begin
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        r_cd[i] <= w_period[i];
                    end
                    r_frames_run     <= '0;
                    r_follower_reset <= 1'b0;
                    r_state          <= c_RUN;
                end
                c_RUN: begin
                    // Collision wins over a coincident tick: no strobes that frame.
                    if (bus.collision) begin
                        r_state <= c_HALT;
                    end else if (bus.frame_tick && !bus.pause) begin
                        r_move <= w_fire;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            r_cd[i] <= w_cd_next[i];
                        end
                        if (r_frames_run != c_FRAMES_MAX) begin
                            r_frames_run <= r_frames_run + 16'd1;
                        end
                    end
                end
                c_HALT: begin
                    if (bus.start) begin
                        r_state          <= c_LOAD;
                        r_follower_reset <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.move           = r_move;
    assign bus.follower_reset = r_follower_reset;
    assign bus.state          = r_state;
    assign bus.frames_run     = r_frames_run;
endmodule
`default_nettype wire

// File: tb/tb_lane_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_move_scheduler
// Brief    : Scoreboard bench for lane_move_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lane_move_scheduler;
    typedef struct packed {
        logic [3:0]  move;
        logic        frst;
        logic [1:0]  state;
        logic [15:0] frames;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] period;
    int          n_vec;
    int          n_err;
    exp_t        sb[$];

    logic [1:0]  m_state;
    logic [3:0]  m_move;
    logic        m_frst;
    logic [15:0] m_frames;
    logic [3:0]  m_cd [4];

    lane_move_scheduler_if #(.NUM_LANES(4), .CNT_W(4)) bus ();

    lane_move_scheduler #(.NUM_LANES(4), .CNT_W(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference behaviour, written straight from the lane/state rules.
    task automatic model_step(input logic rst_n, input logic tick, input logic st,
                              input logic pz, input logic col, input logic [15:0] per);
        logic [3:0] p;
        logic [3:0] eff;
        if (!rst_n) begin
            m_state = 2'd0; m_move = 4'd0; m_frames = 16'd0;
            for (int i = 0; i < 4; i++) m_cd[i] = 4'd0;
        end else begin
            m_move = 4'd0;
            case (m_state)
                2'd0: if (st) m_state = 2'd1;
                2'd1: begin
                    for (int i = 0; i < 4; i++) m_cd[i] = per[i*4 +: 4];
                    m_frames = 16'd0;
                    m_state  = 2'd2;
                end
                2'd2: begin
                    if (col) m_state = 2'd3;
                    else if (tick && !pz) begin
                        for (int i = 0; i < 4; i++) begin
                            p   = per[i*4 +: 4];
                            eff = (m_cd[i] == 4'd0) ? p : m_cd[i];
                            if (p == 4'd0) m_cd[i] = 4'd0;
                            else if (eff <= 4'd1) begin m_move[i] = 1'b1; m_cd[i] = p; end
                            else m_cd[i] = eff - 4'd1;
                        end
                        if (m_frames != 16'hFFFF) m_frames = m_frames + 16'd1;
                    end
                end
                default: if (st) m_state = 2'd1;
            endcase
        end
        m_frst = (m_state == 2'd0) || (m_state == 2'd1);
    endtask

    task automatic cycle(input logic rst_n, input logic tick, input logic st,
                         input logic pz, input logic col);
        exp_t e;
        @(negedge clk);
        reset          = rst_n;
        bus.frame_tick = tick;
        bus.start      = st;
        bus.pause      = pz;
        bus.collision  = col;
        bus.lane_period = period;
        model_step(rst_n, tick, st, pz, col, period);
        e.move = m_move; e.frst = m_frst; e.state = m_state; e.frames = m_frames;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_move",   {28'd0, bus.move},           {28'd0, e.move});
            check("sb_frst",   {31'd0, bus.follower_reset}, {31'd0, e.frst});
            check("sb_state",  {30'd0, bus.state},          {30'd0, e.state});
            check("sb_frames", {16'd0, bus.frames_run},     {16'd0, e.frames});
        end
    end

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b0; period = 16'h3210;
        bus.frame_tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        bus.collision = 1'b0; bus.lane_period = period;

        // reset then start
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("rst_state", {30'd0, bus.state}, 32'd0);
        check("rst_frst",  {31'd0, bus.follower_reset}, 32'd1);
        check("rst_frames", {16'd0, bus.frames_run}, 32'd0);
        cycle(1, 1, 0, 0, 0);
        check("idle_tick_ignored", {30'd0, bus.state}, 32'd0);
        cycle(1, 0, 1, 0, 0);
        check("load_state", {30'd0, bus.state}, 32'd1);
        check("load_frst",  {31'd0, bus.follower_reset}, 32'd1);
        cycle(1, 0, 1, 0, 0);
        check("run_state", {30'd0, bus.state}, 32'd2);
        check("run_frst",  {31'd0, bus.follower_reset}, 32'd0);
        check("run_move",  {28'd0, bus.move}, 32'd0);

        // six ticks, then three paused ticks, then ticks 7 and 8
        for (int k = 1; k <= 8; k++) begin
            if (k == 7) begin
                for (int j = 0; j < 3; j++) begin
                    cycle(1, 1, 0, 1, 0);
                    check("pause_move", {28'd0, bus.move}, 32'd0);
                    check("pause_frames", {16'd0, bus.frames_run}, 32'd6);
                    cycle(1, 0, 0, 1, 0);
                end
            end
            cycle(1, 1, 0, 0, 0);
            check("cadence_move", {28'd0, bus.move},
                  {28'd0, (k % 3 == 0), (k % 2 == 0), 1'b1, 1'b0});
            cycle(1, 0, 0, 0, 0);
            check("strobe_one_cycle", {28'd0, bus.move}, 32'd0);
        end
        check("frames_8", {16'd0, bus.frames_run}, 32'd8);

        // collision on a tick
        cycle(1, 1, 0, 0, 1);
        check("col_state", {30'd0, bus.state}, 32'd3);
        check("col_move", {28'd0, bus.move}, 32'd0);
        check("col_frames", {16'd0, bus.frames_run}, 32'd8);
        cycle(1, 1, 0, 0, 0);
        check("halt_hold", {16'd0, bus.frames_run}, 32'd8);
        cycle(1, 0, 1, 0, 0);
        check("restart_load", {30'd0, bus.state}, 32'd1);
        check("restart_frst", {31'd0, bus.follower_reset}, 32'd1);
        cycle(1, 0, 0, 0, 0);
        check("restart_frames", {16'd0, bus.frames_run}, 32'd0);
        check("restart_run", {30'd0, bus.state}, 32'd2);

        // mid-run reset while a strobe is high
        cycle(1, 1, 0, 0, 0);
        check("pre_rst_move", {31'd0, bus.move[1]}, 32'd1);
        cycle(0, 0, 0, 0, 0);
        check("midrst_move", {28'd0, bus.move}, 32'd0);
        check("midrst_state", {30'd0, bus.state}, 32'd0);
        check("midrst_frst", {31'd0, bus.follower_reset}, 32'd1);
        check("midrst_frames", {16'd0, bus.frames_run}, 32'd0);

        // lane1 period 2 -> 5 right after it fires
        period = 16'h0020;
        cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) period = 16'h0050;
            cycle(1, 1, 0, 0, 0);
            check("retime_lane1", {31'd0, bus.move[1]},
                  {31'd0, (k == 2 || k == 4 || k == 9 || k == 14)});
            cycle(1, 0, 0, 0, 0);
        end

        // frames_run saturation
        period = 16'h0000;
        for (int k = 0; k < 65540; k++) cycle(1, 1, 0, 0, 0);
        check("frames_sat", {16'd0, bus.frames_run}, 32'h0000FFFF);
        cycle(1, 0, 0, 0, 0);

        @(posedge clk);
        #3;
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
